// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// word geometry and the wait-counter width.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam int WORD_BYTES = 8;
    localparam int WORD_SHIFT = 3;
    localparam int CNT_W      = 4;

    // True when a byte address does not sit on a 64-bit word boundary.
    function automatic logic is_misaligned(input logic [63:0] addr);
        return (addr[WORD_SHIFT-1:0] != 3'b000);
    endfunction

endpackage

// File: rtl/data_mem_responder_word_array.sv
// Word-organised storage for the responder: one synchronous port with a
// registered read-data output. The array itself has no reset so contents
// survive a reset; only the read register is cleared.
module dmem_word_array
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                             CLK,
    input  logic                             Reset_L,
    input  logic                             i_we,
    input  logic                             i_re,
    input  logic [ADDR_BITS-WORD_SHIFT-1:0]  i_idx,
    input  logic [63:0]                      i_wdata,
    output logic [63:0]                      o_rdata
);

    localparam int DEPTH = 1 << (ADDR_BITS - WORD_SHIFT);

    logic [63:0] r_mem [DEPTH];
    logic [63:0] r_rdata;

    // Storage write; deliberately not reset so data is retained.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Registered read port; holds its value until the next enabled read.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_rdata <= 64'd0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle target for the core's load/store port. Accepts one request
// in IDLE, waits WAIT_CYCLES, performs the access (or flags it as an
// error) and returns a one-cycle Ready pulse. Busy covers WAIT and RESP.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        Req,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic [63:0] ReadData,
    output logic        Ready,
    output logic        Error,
    output logic        Busy
);

    localparam int IDX_W = ADDR_BITS - WORD_SHIFT;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : CNT_W'(WAIT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [63:0]        r_addr;
    logic [63:0]        r_wdata;
    logic               r_rd;
    logic               r_wr;
    logic               r_ready;
    logic               r_error;
    logic               r_busy;

    logic               w_latch;
    logic               w_access;
    logic [63:0]        w_acc_addr;
    logic [63:0]        w_acc_wdata;
    logic               w_acc_rd;
    logic               w_acc_wr;
    logic               w_illegal;
    logic               w_we;
    logic               w_re;
    logic [IDX_W-1:0]   w_idx;
    logic [63:0]        w_rdata;

    // State register and wait counter.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; also decides when the access happens this edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Req) begin
                    w_latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_access    = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Access operands: live inputs for a zero-wait access from IDLE,
    // otherwise the request captured at acceptance.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_acc_addr  = Address;
            w_acc_wdata = WriteData;
            w_acc_rd    = MemRead;
            w_acc_wr    = MemWrite;
        end else begin
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
            w_acc_rd    = r_rd;
            w_acc_wr    = r_wr;
        end
    end

    // Legality: word aligned, inside storage, exactly one of read/write.
    always_comb begin
        w_illegal = is_misaligned(w_acc_addr)
                  | (w_acc_addr[63:ADDR_BITS] != '0)
                  | (w_acc_rd == w_acc_wr);
    end

    assign w_we  = w_access & ~w_illegal & w_acc_wr;
    assign w_re  = w_access & ~w_illegal & w_acc_rd;
    assign w_idx = w_acc_addr[ADDR_BITS-1:WORD_SHIFT];

    // Request capture at acceptance; a reset discards it.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else if (w_latch) begin
            r_addr  <= Address;
            r_wdata <= WriteData;
            r_rd    <= MemRead;
            r_wr    <= MemWrite;
        end
    end

    // Completion pulse, status and busy flag, all registered.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= w_access;
            r_error <= w_access & w_illegal;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    dmem_word_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (w_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_rdata)
    );

    assign ReadData = w_rdata;
    assign Ready    = r_ready;
    assign Error    = r_error;
    assign Busy     = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance for the
// main scenarios and a WAIT_CYCLES=0 instance for the zero-wait build.
module tb_data_mem_responder;

    logic        CLK = 1'b0;
    logic        Reset_L;

    logic        Req, MemRead, MemWrite;
    logic [63:0] Address, WriteData;
    logic [63:0] ReadData;
    logic        Ready, Error, Busy;

    logic        Req0, MemRead0, MemWrite0;
    logic [63:0] Address0, WriteData0;
    logic [63:0] ReadData0;
    logic        Ready0, Error0, Busy0;

    int checks = 0;
    int passes = 0;

    localparam logic [63:0] PAT = 64'hDEADBEEFCAFEF00D;

    always #5 CLK = ~CLK;

    data_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .Req(Req), .MemRead(MemRead),
        .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .Ready(Ready), .Error(Error), .Busy(Busy)
    );

    data_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .Reset_L(Reset_L), .Req(Req0), .MemRead(MemRead0),
        .MemWrite(MemWrite0), .Address(Address0), .WriteData(WriteData0),
        .ReadData(ReadData0), .Ready(Ready0), .Error(Error0), .Busy(Busy0)
    );

    // One transaction on the W=2 instance; called 1 time unit after an edge.
    task automatic txn(input logic rd, input logic wr, input logic [63:0] a,
                       input logic [63:0] d, output int lat, output int bcnt,
                       output logic err, output logic [63:0] rdat,
                       output logic idle_ok);
        Req = 1'b1; MemRead = rd; MemWrite = wr; Address = a; WriteData = d;
        @(posedge CLK); #1;
        Req = 1'b0;
        lat  = 1;
        bcnt = (Busy === 1'b1) ? 1 : 0;
        while (Ready !== 1'b1 && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
            if (Busy === 1'b1) bcnt++;
        end
        err  = Error;
        rdat = ReadData;
        @(posedge CLK); #1;
        idle_ok = (Ready === 1'b0) && (Busy === 1'b0) && (Error === 1'b0);
    endtask

    task automatic test_reset();
        Reset_L = 1'b0;
        Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Address = 64'd0; WriteData = 64'd0;
        Req0 = 1'b0; MemRead0 = 1'b0; MemWrite0 = 1'b0; Address0 = 64'd0; WriteData0 = 64'd0;
        #2;
        checks++;
        if ({ReadData, Ready, Error, Busy} !== 67'd0)
            $display("FAIL reset_state: got rd=%h rdy=%b err=%b busy=%b, want all 0",
                     ReadData, Ready, Error, Busy);
        else passes++;
        @(posedge CLK); #1;
        Reset_L = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_write_read();
        int lat, bcnt; logic err, ok; logic [63:0] rdat;
        txn(1'b0, 1'b1, 64'h10, PAT, lat, bcnt, err, rdat, ok);
        checks++;
        if (lat !== 3 || err !== 1'b0 || bcnt !== 3 || !ok || rdat !== 64'd0)
            $display("FAIL write_0x10: lat=%0d err=%b busy=%0d idle=%b rd=%h, want 3 0 3 1 0",
                     lat, err, bcnt, ok, rdat);
        else passes++;
        txn(1'b1, 1'b0, 64'h10, 64'd0, lat, bcnt, err, rdat, ok);
        checks++;
        if (lat !== 3 || err !== 1'b0 || bcnt !== 3 || !ok || rdat !== PAT)
            $display("FAIL read_0x10: lat=%0d err=%b busy=%0d idle=%b rd=%h, want 3 0 3 1 %h",
                     lat, err, bcnt, ok, rdat, PAT);
        else passes++;
        txn(1'b0, 1'b1, 64'h18, 64'h1818, lat, bcnt, err, rdat, ok);
        checks++;
        if (err !== 1'b0 || lat !== 3)
            $display("FAIL write_0x18: lat=%0d err=%b, want 3 0", lat, err);
        else passes++;
        txn(1'b0, 1'b1, 64'h20, 64'h2222, lat, bcnt, err, rdat, ok);
        checks++;
        if (err !== 1'b0 || lat !== 3 || rdat !== PAT)
            $display("FAIL write_0x20: lat=%0d err=%b rd=%h, want 3 0 %h", lat, err, rdat, PAT);
        else passes++;
    endtask

    task automatic test_illegal();
        int lat, bcnt; logic err, ok; logic [63:0] rdat;
        logic [3:0]  v_rd;
        logic [3:0]  v_wr;
        logic [63:0] v_a [4];
        v_rd = 4'b0110; v_wr = 4'b0101;
        v_a[0] = 64'h13; v_a[1] = 64'h100; v_a[2] = 64'h10; v_a[3] = 64'h10;
        for (int i = 0; i < 4; i++) begin
            txn(v_rd[i], v_wr[i], v_a[i], 64'h5555, lat, bcnt, err, rdat, ok);
            checks++;
            if (err !== 1'b1 || lat !== 3 || rdat !== PAT || !ok)
                $display("FAIL illegal_%0d: err=%b lat=%0d rd=%h idle=%b, want 1 3 %h 1",
                         i, err, lat, rdat, ok, PAT);
            else passes++;
        end
        txn(1'b1, 1'b0, 64'h10, 64'd0, lat, bcnt, err, rdat, ok);
        checks++;
        if (rdat !== PAT || err !== 1'b0)
            $display("FAIL illegal_keep_0x10: rd=%h err=%b, want %h 0", rdat, err, PAT);
        else passes++;
    endtask

    task automatic test_busy_no_queue();
        int lat, bcnt; logic err, ok; logic [63:0] rdat;
        Req = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Address = 64'h10; WriteData = 64'd0;
        @(posedge CLK); #1;
        checks++;
        if (Busy !== 1'b1 || Ready !== 1'b0)
            $display("FAIL busy_after_accept: busy=%b rdy=%b, want 1 0", Busy, Ready);
        else passes++;
        MemRead = 1'b0; MemWrite = 1'b1; Address = 64'h18; WriteData = 64'h9999;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checks++;
        if (Ready !== 1'b1 || Error !== 1'b0 || ReadData !== PAT)
            $display("FAIL busy_read_orig: rdy=%b err=%b rd=%h, want 1 0 %h",
                     Ready, Error, ReadData, PAT);
        else passes++;
        Req = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (Busy !== 1'b0 || Ready !== 1'b0)
            $display("FAIL busy_release: busy=%b rdy=%b, want 0 0", Busy, Ready);
        else passes++;
        txn(1'b1, 1'b0, 64'h18, 64'd0, lat, bcnt, err, rdat, ok);
        checks++;
        if (rdat !== 64'h1818 || err !== 1'b0)
            $display("FAIL no_queue_0x18: rd=%h err=%b, want 1818 0", rdat, err);
        else passes++;
    endtask

    task automatic test_reset_mid_store();
        int lat, bcnt; logic err, ok; logic [63:0] rdat;
        Req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Address = 64'h20; WriteData = 64'h1111;
        @(posedge CLK); #1;
        Req = 1'b0;
        #3;
        Reset_L = 1'b0;
        #1;
        checks++;
        if ({ReadData, Ready, Error, Busy} !== 67'd0)
            $display("FAIL async_reset: rd=%h rdy=%b err=%b busy=%b, want all 0",
                     ReadData, Ready, Error, Busy);
        else passes++;
        @(posedge CLK); @(posedge CLK); #1;
        Reset_L = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (Busy !== 1'b0 || Ready !== 1'b0)
            $display("FAIL post_reset_idle: busy=%b rdy=%b, want 0 0", Busy, Ready);
        else passes++;
        txn(1'b1, 1'b0, 64'h20, 64'd0, lat, bcnt, err, rdat, ok);
        checks++;
        if (rdat !== 64'h2222 || err !== 1'b0 || lat !== 3)
            $display("FAIL aborted_store_0x20: rd=%h err=%b lat=%0d, want 2222 0 3",
                     rdat, err, lat);
        else passes++;
    endtask

    task automatic test_wait0();
        logic [5:0] pat;
        logic       rd_ok;
        Req0 = 1'b1; MemRead0 = 1'b0; MemWrite0 = 1'b1; Address0 = 64'h08; WriteData0 = 64'hA5A5;
        @(posedge CLK); #1;
        Req0 = 1'b0;
        checks++;
        if (Ready0 !== 1'b1 || Busy0 !== 1'b1 || Error0 !== 1'b0)
            $display("FAIL w0_write: rdy=%b busy=%b err=%b, want 1 1 0", Ready0, Busy0, Error0);
        else passes++;
        @(posedge CLK); #1;
        checks++;
        if (Ready0 !== 1'b0 || Busy0 !== 1'b0)
            $display("FAIL w0_idle: rdy=%b busy=%b, want 0 0", Ready0, Busy0);
        else passes++;
        Req0 = 1'b1; MemRead0 = 1'b1; MemWrite0 = 1'b0;
        pat = 6'd0; rd_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            pat[i] = Ready0;
            if (Ready0 === 1'b1 && (ReadData0 !== 64'hA5A5 || Error0 !== 1'b0)) rd_ok = 1'b0;
        end
        Req0 = 1'b0;
        checks++;
        if (pat !== 6'b010101 || !rd_ok)
            $display("FAIL w0_back_to_back: ready pattern=%b data_ok=%b, want 010101 1", pat, rd_ok);
        else passes++;
        @(posedge CLK); #1;
        Req0 = 1'b1; MemRead0 = 1'b1; MemWrite0 = 1'b0; Address0 = 64'h09;
        @(posedge CLK); #1;
        Req0 = 1'b0;
        checks++;
        if (Ready0 !== 1'b1 || Error0 !== 1'b1 || ReadData0 !== 64'hA5A5)
            $display("FAIL w0_misaligned: rdy=%b err=%b rd=%h, want 1 1 a5a5",
                     Ready0, Error0, ReadData0);
        else passes++;
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_illegal();
        test_busy_no_queue();
        test_reset_mid_store();
        test_wait0();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
